// File: rtl/fetch_steer_pkg.sv
// Shared fetch-stage widths, the decode bundle record, and a PC stepping helper.
package fetch_steer_pkg;

    localparam int ADDR_W                = 32;
    localparam int BRANCH_HISTORY_REG_SZ = 4;
    localparam int PREFETCH_DISTANCE     = 2;
    localparam int FETCH_INSTS           = PREFETCH_DISTANCE * 2;
    localparam int FETCH_CNT_W           = $clog2(FETCH_INSTS + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]                pc;
        logic [FETCH_CNT_W-1:0]           count;
        logic [BRANCH_HISTORY_REG_SZ-1:0] bhr;
        logic                             pred_taken;
    } fetch_bundle_t;

    // Address of the instruction n words past pc; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] pc_plus_slots(input logic [ADDR_W-1:0] pc,
                                                        input int unsigned       n);
        return pc + ADDR_W'(n << 2);
    endfunction

endpackage

// File: rtl/fetch_steer_taken_sel.sv
// Priority encoder: reports whether any request bit is set and the lowest such index.
module fetch_steer_taken_sel #(
    parameter int N   = 4,
    parameter int K_W = 2
) (
    input  logic [N-1:0]   req,
    output logic           found,
    output logic [K_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = K_W'(i);
            end
        end
    end

endmodule

// File: rtl/fetch_steer.sv
// Fetch-stage next-PC / speculative global history generator feeding the branch
// predictor, packaging each fetched window (cut at the first taken branch) for decode.
module fetch_steer
    import fetch_steer_pkg::*;
#(
    parameter int          BHR_DEPTH      = BRANCH_HISTORY_REG_SZ,
    parameter int          PREFETCH_INSTS = PREFETCH_DISTANCE * 2,
    parameter logic [31:0] RESET_PC       = 32'h0,
    localparam int         CNT_W          = $clog2(PREFETCH_INSTS + 1),
    localparam int         K_W            = (PREFETCH_INSTS > 1) ? $clog2(PREFETCH_INSTS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic [ADDR_W-1:0]         rd_pc,
    output logic [BHR_DEPTH-1:0]      rd_bhr,
    input  logic                      fetch_valid,
    input  logic [PREFETCH_INSTS-1:0] pred_is_branch,
    input  logic [PREFETCH_INSTS-1:0] pred_taken,
    input  logic [ADDR_W-1:0]         pred_target [PREFETCH_INSTS],
    input  logic                      redirect_en,
    input  logic [ADDR_W-1:0]         redirect_pc,
    input  logic [BHR_DEPTH-1:0]      redirect_bhr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [CNT_W-1:0]          out_count,
    output logic [BHR_DEPTH-1:0]      out_bhr,
    output logic                      out_pred_taken
);

    logic                 found;
    logic [K_W-1:0]       k;
    logic [CNT_W-1:0]     count;
    logic [ADDR_W-1:0]    next_pc;
    logic [BHR_DEPTH-1:0] next_bhr;
    logic [ADDR_W-1:0]    redirect_pc_aligned;
    logic                 advance;

    fetch_steer_taken_sel #(
        .N   (PREFETCH_INSTS),
        .K_W (K_W)
    ) u_taken_sel (
        .req   (pred_taken & pred_is_branch),
        .found (found),
        .idx   (k)
    );

    assign redirect_pc_aligned = redirect_pc & ~ADDR_W'(3);
    assign advance = fetch_valid && (!out_valid || out_ready) && !redirect_en;

    // Window truncation and speculative history: every branch up to and including
    // the first taken one shifts in a bit; only that taken branch shifts in a 1.
    always_comb begin
        count    = CNT_W'(PREFETCH_INSTS);
        next_pc  = pc_plus_slots(rd_pc, PREFETCH_INSTS);
        next_bhr = rd_bhr;
        if (found) begin
            count   = CNT_W'(k) + CNT_W'(1);
            next_pc = pred_target[k];
        end
        for (int i = 0; i < PREFETCH_INSTS; i++) begin
            if (pred_is_branch[i] && (!found || K_W'(i) <= k)) begin
                next_bhr = {next_bhr[BHR_DEPTH-2:0], found && (K_W'(i) == k)};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_pc          <= RESET_PC;
            rd_bhr         <= '0;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_count      <= '0;
            out_bhr        <= '0;
            out_pred_taken <= 1'b0;
        end else if (redirect_en) begin
            out_valid <= 1'b0;
            rd_pc     <= redirect_pc_aligned;
            rd_bhr    <= redirect_bhr;
        end else if (advance) begin
            out_valid      <= 1'b1;
            out_pc         <= rd_pc;
            out_count      <= count;
            out_bhr        <= rd_bhr;
            out_pred_taken <= found;
            rd_pc          <= next_pc;
            rd_bhr         <= next_bhr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_steer.sv
// Directed bench for fetch_steer: a table of per-cycle vectors plus redirect/reset sequences.
module tb_fetch_steer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rd_pc;
    logic [3:0]  rd_bhr;
    logic        fetch_valid;
    logic [3:0]  pred_is_branch;
    logic [3:0]  pred_taken;
    logic [31:0] pred_target [4];
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [3:0]  redirect_bhr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  out_count;
    logic [3:0]  out_bhr;
    logic        out_pred_taken;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    fetch_steer #(
        .BHR_DEPTH      (4),
        .PREFETCH_INSTS (4),
        .RESET_PC       (32'h0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rd_pc          (rd_pc),
        .rd_bhr         (rd_bhr),
        .fetch_valid    (fetch_valid),
        .pred_is_branch (pred_is_branch),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .redirect_bhr   (redirect_bhr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_count      (out_count),
        .out_bhr        (out_bhr),
        .out_pred_taken (out_pred_taken)
    );

    typedef struct {
        logic        fv;
        logic [3:0]  br;
        logic [3:0]  tk;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] e_rd_pc;
        logic [3:0]  e_bhr;
        logic        e_ov;
        logic [31:0] e_opc;
        logic [2:0]  e_cnt;
        logic [3:0]  e_obhr;
        logic        e_opt;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_rd_pc, input logic [3:0] e_bhr,
                             input logic e_ov, input logic [31:0] e_opc, input logic [2:0] e_cnt,
                             input logic [3:0] e_obhr, input logic e_opt);
        check({tag, " rd_pc"}, rd_pc, e_rd_pc);
        check({tag, " rd_bhr"}, 32'(rd_bhr), 32'(e_bhr));
        check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, " out_pc"}, out_pc, e_opc);
        check({tag, " out_count"}, 32'(out_count), 32'(e_cnt));
        check({tag, " out_bhr"}, 32'(out_bhr), 32'(e_obhr));
        check({tag, " out_pred_taken"}, 32'(out_pred_taken), 32'(e_opt));
    endtask

    task automatic drive(input logic fv, input logic [3:0] br, input logic [3:0] tk,
                         input logic [31:0] tgt, input logic rdy);
        fetch_valid    = fv;
        pred_is_branch = br;
        pred_taken     = tk;
        for (int j = 0; j < 4; j++) pred_target[j] = tgt;
        out_ready      = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //           fv  br       tk       tgt            rdy  rd_pc          bhr      ov  opc            cnt   obhr     opt
        vecs[0]  = '{1, 4'b0000, 4'b0000, 32'h0,         1, 32'h10,        4'b0000, 1, 32'h0,         3'd4, 4'b0000, 0};
        vecs[1]  = '{1, 4'b0000, 4'b0000, 32'h0,         1, 32'h20,        4'b0000, 1, 32'h10,        3'd4, 4'b0000, 0};
        vecs[2]  = '{1, 4'b0110, 4'b0100, 32'h100,       1, 32'h100,       4'b0001, 1, 32'h20,        3'd3, 4'b0000, 1};
        vecs[3]  = '{1, 4'b0110, 4'b0100, 32'h200,       1, 32'h200,       4'b0101, 1, 32'h100,       3'd3, 4'b0001, 1};
        vecs[4]  = '{1, 4'b1011, 4'b1010, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 4'b0101, 1, 32'h200,       3'd2, 4'b0101, 1};
        vecs[5]  = '{1, 4'b0001, 4'b0000, 32'h0,         1, 32'h8,         4'b1010, 1, 32'hFFFF_FFF8, 3'd4, 4'b0101, 0};
        vecs[6]  = '{1, 4'b0000, 4'b1111, 32'h500,       1, 32'h18,        4'b1010, 1, 32'h8,         3'd4, 4'b1010, 0};
        vecs[7]  = '{0, 4'b0000, 4'b0000, 32'h0,         1, 32'h18,        4'b1010, 0, 32'h8,         3'd4, 4'b1010, 0};
        vecs[8]  = '{1, 4'b1000, 4'b1000, 32'h40,        1, 32'h40,        4'b0101, 1, 32'h18,        3'd4, 4'b1010, 1};
        vecs[9]  = '{1, 4'b0000, 4'b0000, 32'h0,         0, 32'h40,        4'b0101, 1, 32'h18,        3'd4, 4'b1010, 1};
        vecs[10] = '{1, 4'b0000, 4'b0000, 32'h0,         0, 32'h40,        4'b0101, 1, 32'h18,        3'd4, 4'b1010, 1};
        vecs[11] = '{1, 4'b0000, 4'b0000, 32'h0,         0, 32'h40,        4'b0101, 1, 32'h18,        3'd4, 4'b1010, 1};
        vecs[12] = '{1, 4'b0000, 4'b0000, 32'h0,         1, 32'h50,        4'b0101, 1, 32'h40,        3'd4, 4'b0101, 0};
        vecs[13] = '{0, 4'b0000, 4'b0000, 32'h0,         0, 32'h50,        4'b0101, 1, 32'h40,        3'd4, 4'b0101, 0};
        vecs[14] = '{0, 4'b0000, 4'b0000, 32'h0,         1, 32'h50,        4'b0101, 0, 32'h40,        3'd4, 4'b0101, 0};

        reset        = 1'b0;
        redirect_en  = 1'b0;
        redirect_pc  = '0;
        redirect_bhr = '0;
        drive(0, 4'b0, 4'b0, 32'h0, 1);
        repeat (2) tick();
        check_all("reset", 32'h0, 4'b0000, 0, 32'h0, 3'd0, 4'b0000, 0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fv, vecs[i].br, vecs[i].tk, vecs[i].tgt, vecs[i].rdy);
            tick();
            check_all($sformatf("v%0d", i), vecs[i].e_rd_pc, vecs[i].e_bhr, vecs[i].e_ov,
                      vecs[i].e_opc, vecs[i].e_cnt, vecs[i].e_obhr, vecs[i].e_opt);
        end

        // Redirect coincident with an otherwise-advancing fetch; low PC bits are dropped.
        drive(1, 4'b0001, 4'b0001, 32'h900, 1);
        redirect_en  = 1'b1;
        redirect_pc  = 32'h403;
        redirect_bhr = 4'b1010;
        tick();
        check_all("redir", 32'h400, 4'b1010, 0, 32'h40, 3'd4, 4'b0101, 0);
        redirect_en = 1'b0;
        drive(1, 4'b0000, 4'b0000, 32'h0, 0);
        tick();
        check_all("post_redir", 32'h410, 4'b1010, 1, 32'h400, 3'd4, 4'b1010, 0);

        // Redirect while a bundle is stalled discards it.
        redirect_en  = 1'b1;
        redirect_pc  = 32'h800;
        redirect_bhr = 4'b0011;
        tick();
        check_all("redir_stall", 32'h800, 4'b0011, 0, 32'h400, 3'd4, 4'b1010, 0);
        redirect_en = 1'b0;
        tick();
        check_all("refill", 32'h810, 4'b0011, 1, 32'h800, 3'd4, 4'b0011, 0);

        // Reset mid-stall, with a competing redirect, returns everything to reset values.
        reset        = 1'b0;
        redirect_en  = 1'b1;
        redirect_pc  = 32'hC00;
        tick();
        check_all("reset_stall", 32'h0, 4'b0000, 0, 32'h0, 3'd0, 4'b0000, 0);
        reset       = 1'b1;
        redirect_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
